// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the dual-clock FIFO: synchronized write pointer in,
// consumer handshake in, RAM address and read-domain status out.
//   wptr_gray_sync : Gray write pointer, already synchronized to clk
//   rd_en/clr_err  : consumer read request / underflow clear
//   rd_addr        : RAM read address
//   rd_ptr_gray    : registered Gray read pointer to write domain
//   rd_valid, empty, almost_empty, rd_count, underflow : status
interface fifo_rd_ctrl_if #(
  parameter int unsigned PTR_WIDTH = 4
);
  logic [PTR_WIDTH:0]   wptr_gray_sync;
  logic                 rd_en;
  logic                 clr_err;
  logic [PTR_WIDTH-1:0] rd_addr;
  logic [PTR_WIDTH:0]   rd_ptr_gray;
  logic                 rd_valid;
  logic                 empty;
  logic                 almost_empty;
  logic [PTR_WIDTH:0]   rd_count;
  logic                 underflow;

  // Consumer / write-pointer source side
  modport master (
    output wptr_gray_sync, rd_en, clr_err,
    input  rd_addr, rd_ptr_gray, rd_valid, empty, almost_empty, rd_count, underflow
  );

  // Read controller side
  modport slave (
    input  wptr_gray_sync, rd_en, clr_err,
    output rd_addr, rd_ptr_gray, rd_valid, empty, almost_empty, rd_count, underflow
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO (read clock domain).
// Owns the binary/Gray read pointer, drives the RAM read address and
// produces empty, almost_empty, rd_count and a sticky underflow flag.
//   clk  : read-domain clock
//   rst  : asynchronous active-high reset
//   bus  : fifo_rd_ctrl_if.slave (see interface for signal list)
module fifo_rd_ctrl #(
  parameter int unsigned PTR_WIDTH = 4,
  parameter int unsigned AE_LEVEL  = 2
) (
  input  logic           clk,
  input  logic           rst,
  fifo_rd_ctrl_if.slave  bus
);
  localparam int unsigned PW = PTR_WIDTH + 1;

  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rgray;
  logic          r_valid;
  logic          r_empty;
  logic          r_ae;
  logic [PW-1:0] r_count;
  logic          r_uflow;

  logic [PW-1:0] w_wbin;
  logic          w_accept;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rgray_next;
  logic [PW-1:0] w_count;

  // Gray-to-binary: bit i is the XOR of all Gray bits from i upward
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      w_wbin[i] = ^(bus.wptr_gray_sync >> i);
    end
  end

  // Accept is qualified by the registered empty, never a combinational one
  assign w_accept     = bus.rd_en & ~r_empty;
  assign w_rbin_next  = r_rbin + PW'(w_accept);
  assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
  // Modulo subtraction keeps the count correct across pointer wrap
  assign w_count      = w_wbin - w_rbin_next;

  // Pointer and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rbin  <= '0;
      r_rgray <= '0;
      r_valid <= 1'b0;
      r_empty <= 1'b1;
      r_ae    <= 1'b1;
      r_count <= '0;
      r_uflow <= 1'b0;
    end else begin
      r_rbin  <= w_rbin_next;
      r_rgray <= w_rgray_next;
      r_valid <= w_accept;
      r_empty <= (w_rgray_next == bus.wptr_gray_sync);
      r_ae    <= (w_count <= PW'(AE_LEVEL));
      r_count <= w_count;
      // Set has priority over clear
      r_uflow <= (bus.rd_en & r_empty) | (r_uflow & ~bus.clr_err);
    end
  end

  assign bus.rd_addr      = r_rbin[PTR_WIDTH-1:0];
  assign bus.rd_ptr_gray  = r_rgray;
  assign bus.rd_valid     = r_valid;
  assign bus.empty        = r_empty;
  assign bus.almost_empty = r_ae;
  assign bus.rd_count     = r_count;
  assign bus.underflow    = r_uflow;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;
  localparam int unsigned PTR_WIDTH = 4;
  localparam int unsigned AE_LEVEL  = 2;
  localparam int DEPTH = 16;
  localparam int MODV  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.PTR_WIDTH(PTR_WIDTH)) bus ();

  fifo_rd_ctrl #(.PTR_WIDTH(PTR_WIDTH), .AE_LEVEL(AE_LEVEL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pointers as plain integers modulo 2*DEPTH
  int m_rptr, m_wptr, m_count;
  bit m_empty, m_ae, m_valid, m_uf;

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rptr = 0; m_count = 0; m_empty = 1; m_ae = 1; m_valid = 0; m_uf = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd_addr"},      32'(bus.rd_addr),      32'(m_rptr % DEPTH));
    chk({tag, ".rd_ptr_gray"},  32'(bus.rd_ptr_gray),  32'(to_gray(m_rptr)));
    chk({tag, ".rd_valid"},     32'(bus.rd_valid),     32'(m_valid));
    chk({tag, ".empty"},        32'(bus.empty),        32'(m_empty));
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(m_ae));
    chk({tag, ".rd_count"},     32'(bus.rd_count),     32'(m_count));
    chk({tag, ".underflow"},    32'(bus.underflow),    32'(m_uf));
  endtask

  // One clock: drive inputs at negedge, advance model, check after posedge
  task automatic step(input string tag, input bit rd, input bit clr);
    bit acc;
    int rn;
    @(negedge clk);
    bus.rd_en          = rd;
    bus.clr_err        = clr;
    bus.wptr_gray_sync = to_gray(m_wptr);
    acc   = rd && !m_empty;
    rn    = (m_rptr + (acc ? 1 : 0)) % MODV;
    m_uf  = (rd && m_empty) || (m_uf && !clr);
    m_valid = acc;
    m_count = (m_wptr - rn + MODV) % MODV;
    m_empty = (m_count == 0);
    m_ae    = (m_count <= int'(AE_LEVEL));
    m_rptr  = rn;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  logic [4:0] exp_gray [4];

  initial begin
    bus.rd_en = 0; bus.clr_err = 0; bus.wptr_gray_sync = '0;
    m_wptr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check_all("reset");

    // Read on empty: underflow, no movement; set+clear same cycle keeps it set
    step("uf_set", 1, 0);
    step("uf_set_clr", 1, 1);
    chk("uf_set_wins", 32'(bus.underflow), 32'd1);
    step("uf_clr", 0, 1);
    chk("uf_cleared", 32'(bus.underflow), 32'd0);

    // Four entries, four back-to-back reads
    m_wptr = 4;
    step("fill4", 0, 0);
    chk("fill4.count", 32'(bus.rd_count), 32'd4);
    exp_gray[0] = 5'b00001; exp_gray[1] = 5'b00011;
    exp_gray[2] = 5'b00010; exp_gray[3] = 5'b00110;
    for (int i = 0; i < 4; i++) begin
      step("burst", 1, 0);
      chk("burst.gray_const", 32'(bus.rd_ptr_gray), 32'(exp_gray[i]));
      chk("burst.addr_const", 32'(bus.rd_addr), 32'(i + 1));
      chk("burst.ae_const", 32'(bus.almost_empty), 32'(i >= 1));
    end
    chk("burst.empty_end", 32'(bus.empty), 32'd1);
    step("burst_tail", 0, 0);

    // Walk read pointer up to 31 to exercise wrap
    for (int k = 0; k < 200 && m_rptr != 31; k++) begin
      m_wptr = (m_rptr + 1) % MODV;
      step("walk", 1, 0);
    end
    chk("walk.reached31", 32'(m_rptr), 32'd31);
    m_wptr = 1;
    step("wrap_pre", 0, 0);
    chk("wrap.count2", 32'(bus.rd_count), 32'd2);
    chk("wrap.gray_pre", 32'(bus.rd_ptr_gray), 32'h10);
    chk("wrap.addr_pre", 32'(bus.rd_addr), 32'd15);
    step("wrap", 1, 0);
    chk("wrap.gray_post", 32'(bus.rd_ptr_gray), 32'h00);
    chk("wrap.addr_post", 32'(bus.rd_addr), 32'd0);
    chk("wrap.count1", 32'(bus.rd_count), 32'd1);

    // Same-cycle write arrival and accept with one entry
    m_wptr = 2;
    step("same_cycle", 1, 0);
    chk("same_cycle.empty", 32'(bus.empty), 32'd0);
    chk("same_cycle.count", 32'(bus.rd_count), 32'd1);
    step("drain", 1, 0);
    step("drain2", 0, 0);

    // Full FIFO
    m_wptr = (m_rptr + DEPTH) % MODV;
    step("full", 0, 0);
    chk("full.count", 32'(bus.rd_count), 32'd16);
    chk("full.empty", 32'(bus.empty), 32'd0);
    chk("full.ae", 32'(bus.almost_empty), 32'd0);

    // Async reset mid-read with rd_valid in flight
    for (int k = 0; k < 40 && m_rptr != 7; k++) step("to7", 1, 0);
    chk("pre_rst.valid", 32'(bus.rd_valid), 32'd1);
    chk("pre_rst.rptr7", 32'(bus.rd_addr), 32'd7);
    #1;
    rst = 1;
    #1;
    model_reset();
    m_wptr = 0;
    check_all("async_rst");
    @(negedge clk);
    bus.wptr_gray_sync = '0; bus.rd_en = 0; bus.clr_err = 0;
    rst = 0;
    #1;
    check_all("rst_release");

    // Randomized traffic against the model
    for (int k = 0; k < 500; k++) begin
      int occ;
      occ = (m_wptr - m_rptr + MODV) % MODV;
      if ($urandom_range(0, 2) != 0 && occ < DEPTH) m_wptr = (m_wptr + 1) % MODV;
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the dual-clock FIFO, clocked in the read domain. It receives the write pointer in Gray code, already passed through the two-flop synchronizer. It owns the read pointer (binary and Gray), drives the RAM read address, and generates the empty, almost-empty, fill-count and underflow status. Its Gray read pointer goes back to the write domain through a synchronizer instance of the same kind.

Parameters:
PTR_WIDTH, 4, address width; FIFO depth DEPTH = 2^PTR_WIDTH; pointers are PTR_WIDTH+1 bits (one wrap bit).
AE_LEVEL, 2, almost_empty asserts when fill count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
clk  input  1  read-domain clock
rst  input  1  asynchronous, active-high reset
wptr_gray_sync  input  PTR_WIDTH+1  write pointer, Gray, already synchronized to clk
rd_en  input  1  read request from consumer
clr_err  input  1  clears the underflow flag
rd_addr  output  PTR_WIDTH  RAM read address, equal to rbin[PTR_WIDTH-1:0]
rd_ptr_gray  output  PTR_WIDTH+1  registered Gray read pointer, sent to write-domain synchronizer
rd_valid  output  1  RAM read data valid (1-cycle synchronous RAM)
empty  output  1  FIFO empty, registered
almost_empty  output  1  fill count <= AE_LEVEL, registered
rd_count  output  PTR_WIDTH+1  fill level as seen in read domain, registered, range 0..DEPTH
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (async, on rst high) values:
  - rbin = 0, rd_ptr_gray = 0, rd_addr = 0
  - rd_valid = 0, empty = 1, almost_empty = 1, rd_count = 0, underflow = 0
- Accept condition: rd_accept = rd_en && !empty, evaluated on the registered empty.
- Pointer update:
  - rbin_next = rbin + rd_accept, modulo 2^(PTR_WIDTH+1); wraps from all-ones to 0 with no special case.
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - rd_ptr_gray is registered from rgray_next, so it changes by at most one bit per cycle.
- Write pointer decode:
  - wbin[i] = XOR of wptr_gray_sync[PTR_WIDTH:i], combinational.
- Status registers (updated every cycle):
  - empty <= (rgray_next == wptr_gray_sync).
  - rd_count <= wbin - rbin_next, modulo 2^(PTR_WIDTH+1).
  - almost_empty <= (wbin - rbin_next) <= AE_LEVEL.
- Latency:
  - Address: rd_addr presents the new entry the cycle after an accept.
  - Data: rd_valid = rd_accept registered, i.e. high exactly one cycle after each accepted read. The RAM data for the pre-accept rd_addr is valid in that cycle.
  - Back-to-back: an accept every cycle is allowed while !empty, giving full throughput.
  - Write to visible: a write becomes visible two read-clock cycles after the Gray pointer changes, via the external synchronizer, plus one cycle for the empty register. This is pessimistic-safe: empty may stay high late, never deasserts early.
- Last entry: with rd_count = 1, an accept sets empty = 1 the next cycle. An rd_en in that next cycle is an underflow attempt.
- Underflow:
  - rd_en && empty: no pointer movement, rd_valid stays 0, underflow sets at the next edge.
  - Cleared only by clr_err or rst.
  - If set and clear occur in the same cycle, set wins.
- Simultaneous events: a new wptr_gray_sync value in the same cycle as an accept is handled in one evaluation. The count uses both the new wbin and rbin_next.
- Reset mid-operation: all state returns to reset values immediately. Any rd_valid pulse in flight is dropped.
- No full flag here; full is generated by the write-side controller.

Test Plan:
1. Reset release with wptr_gray_sync = 0 -> empty = 1, almost_empty = 1, rd_count = 0, rd_addr = 0, rd_ptr_gray = 0; rd_en pulse -> underflow = 1, rd_valid stays 0, rd_addr stays 0.
2. wptr_gray_sync = 5'b00110 (bin 4), AE_LEVEL = 2 -> next cycle empty = 0, rd_count = 4, almost_empty = 0. Four back-to-back rd_en:
   - rd_addr steps 1, 2, 3, 4
   - rd_ptr_gray goes 00001, 00011, 00010, 00110
   - rd_valid high for 4 cycles, each one cycle after its accept
   - rd_count goes 3, 2, 1, 0; almost_empty rises when count reaches 2; empty = 1 after the 4th accept
3. Wrap: drive the write pointer and reads through 32 entries (PTR_WIDTH = 4) -> rbin wraps from 31 to 0, rd_ptr_gray goes 10000 -> 00000, rd_addr goes 15 -> 0. rd_count is correct across the wrap: with wbin = 1 and rbin = 31, rd_count = 2.
4. Full FIFO: wptr bin 16, rbin 0 -> rd_count = 16, empty = 0, almost_empty = 0.
5. Same-cycle write arrival and accept, with rd_count = 1 -> empty stays 0 and rd_count stays 1. Separately, underflow set and clr_err in the same cycle -> underflow = 1; clr_err alone the next cycle -> 0.
6. Assert rst while rbin = 7 and rd_valid = 1 -> all outputs return to reset values asynchronously, before the next clk edge.
